// File: rtl/mfcc_mel_filter_acc.sv
// Mel filterbank accumulator: weights each power bin by its triangular-filter coefficient,
// sums into NFILT saturating mel energies, then streams them out over valid/ready.
module mfcc_mel_filter_acc #(
  parameter int NBIN   = 257,
  parameter int NFILT  = 26,
  parameter int ADDR_W = 9,
  parameter int PWR_W  = 32,
  parameter int COEF_W = 16,
  parameter int FIDX_W = 5,
  parameter int ACC_W  = 56
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pwr_valid,
  output logic                     pwr_ready,
  input  logic [PWR_W-1:0]         pwr_data,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [FIDX_W+COEF_W-1:0] rom_data,
  output logic                     mel_valid,
  input  logic                     mel_ready,
  output logic [ACC_W-1:0]         mel_data,
  output logic [FIDX_W-1:0]        mel_idx,
  output logic                     mel_last
);

  localparam int PROD_W = COEF_W + 1 + PWR_W;
  localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN1, DRAIN2, OUT} state_t;

  state_t              state, next_state;
  logic [ADDR_W-1:0]   bin_cnt;
  logic [FIDX_W-1:0]   out_cnt, next_idx;
  logic                accept, out_fire, frame_done;
  logic [PWR_W-1:0]    p1;
  logic                v1, v2;
  logic [PROD_W-1:0]   pa, pb;
  logic [FIDX_W-1:0]   fidx2;
  logic [ACC_W-1:0]    acc [NFILT];
  logic [FIDX_W-1:0]   rom_fidx;
  logic [COEF_W-1:0]   rom_w;
  logic [COEF_W:0]     rom_wc;

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [PROD_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_W'(ACC_MAX)) return ACC_MAX;
    return s[ACC_W-1:0];
  endfunction

  assign rom_fidx   = rom_data[COEF_W +: FIDX_W];
  assign rom_w      = rom_data[COEF_W-1:0];
  // Complementary weight of the falling slope; w=0 gives the full 2**COEF_W.
  assign rom_wc     = {1'b1, {COEF_W{1'b0}}} - {1'b0, rom_w};
  assign accept     = pwr_valid && pwr_ready;
  assign out_fire   = mel_valid && mel_ready;
  assign frame_done = out_fire && mel_last;
  assign rom_addr   = bin_cnt;
  assign next_idx   = out_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    pwr_ready  = 1'b0;
    case (state)
      IDLE, ACCUM: begin
        pwr_ready = rst_n;
        if (pwr_valid)
          next_state = (bin_cnt == ADDR_W'(NBIN-1)) ? DRAIN1 : ACCUM;
      end
      DRAIN1:  next_state = DRAIN2;
      DRAIN2:  next_state = OUT;
      OUT:     if (frame_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_cnt   <= '0;
      out_cnt   <= '0;
      p1        <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      pa        <= '0;
      pb        <= '0;
      fidx2     <= '0;
      mel_valid <= 1'b0;
      mel_data  <= '0;
      mel_idx   <= '0;
      mel_last  <= 1'b0;
      for (int j = 0; j < NFILT; j++) acc[j] <= '0;
    end else begin
      if (accept) begin
        bin_cnt <= (bin_cnt == ADDR_W'(NBIN-1)) ? '0 : bin_cnt + 1'b1;
        p1      <= pwr_data;
      end
      v1 <= accept;
      v2 <= v1;
      if (v1) begin
        pa    <= PROD_W'(rom_w) * PROD_W'(p1);
        pb    <= PROD_W'(rom_wc) * PROD_W'(p1);
        fidx2 <= rom_fidx;
      end
      // Rising slope lands on filter fidx, falling slope on fidx-1; never the same entry.
      for (int j = 0; j < NFILT; j++) begin
        if (frame_done)
          acc[j] <= '0;
        else if (v2 && fidx2 == FIDX_W'(j))
          acc[j] <= sat_add(acc[j], pa);
        else if (v2 && fidx2 == FIDX_W'(j+1))
          acc[j] <= sat_add(acc[j], pb);
      end
      // Output register loads one cycle after entering OUT, after the last update settles.
      if (state == OUT) begin
        if (!mel_valid) begin
          mel_valid <= 1'b1;
          mel_data  <= acc[out_cnt];
          mel_idx   <= out_cnt;
          mel_last  <= (out_cnt == FIDX_W'(NFILT-1));
        end else if (mel_ready) begin
          if (mel_last) begin
            mel_valid <= 1'b0;
            mel_data  <= '0;
            mel_idx   <= '0;
            mel_last  <= 1'b0;
            out_cnt   <= '0;
          end else begin
            out_cnt  <= next_idx;
            mel_data <= acc[next_idx];
            mel_idx  <= next_idx;
            mel_last <= (next_idx == FIDX_W'(NFILT-1));
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mfcc_mel_filter_acc.sv
// Randomized self-checking bench for mfcc_mel_filter_acc against a plain-arithmetic
// filterbank model; the ROM is modelled as a registered lookup table.
module tb_mfcc_mel_filter_acc;

  localparam int NBIN   = 257;
  localparam int NFILT  = 26;
  localparam int ADDR_W = 9;
  localparam int PWR_W  = 32;
  localparam int COEF_W = 16;
  localparam int FIDX_W = 5;
  localparam int ACC_W  = 56;
  localparam int GUARD  = 20000;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     pwr_valid;
  logic                     pwr_ready;
  logic [PWR_W-1:0]         pwr_data;
  logic [ADDR_W-1:0]        rom_addr;
  logic [FIDX_W+COEF_W-1:0] rom_data;
  logic                     mel_valid;
  logic                     mel_ready;
  logic [ACC_W-1:0]         mel_data;
  logic [FIDX_W-1:0]        mel_idx;
  logic                     mel_last;

  logic [FIDX_W+COEF_W-1:0] rom [2**ADDR_W];
  logic [PWR_W-1:0]         pwr [NBIN];
  logic [ACC_W-1:0]         expv [NFILT];
  logic [ACC_W-1:0]         got  [NFILT];
  int                       errors = 0;
  int                       checks = 0;
  longint                   cyc = 0;
  longint                   last_edge = 0;

  mfcc_mel_filter_acc #(
    .NBIN(NBIN), .NFILT(NFILT), .ADDR_W(ADDR_W), .PWR_W(PWR_W),
    .COEF_W(COEF_W), .FIDX_W(FIDX_W), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pwr_valid(pwr_valid), .pwr_ready(pwr_ready), .pwr_data(pwr_data),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .mel_valid(mel_valid), .mel_ready(mel_ready), .mel_data(mel_data),
    .mel_idx(mel_idx), .mel_last(mel_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference: total weighted power per filter, clipped once at the end (all terms are >= 0).
  task automatic build_model();
    logic [127:0] sum [NFILT];
    for (int j = 0; j < NFILT; j++) sum[j] = '0;
    for (int b = 0; b < NBIN; b++) begin
      int f;
      logic [127:0] w, p;
      f = int'(rom[b][COEF_W +: FIDX_W]);
      w = 128'(rom[b][COEF_W-1:0]);
      p = 128'(pwr[b]);
      if (f < NFILT) sum[f] += w * p;
      if (f >= 1 && f <= NFILT) sum[f-1] += (128'(65536) - w) * p;
    end
    for (int j = 0; j < NFILT; j++)
      expv[j] = (sum[j] > 128'({ACC_W{1'b1}})) ? {ACC_W{1'b1}} : sum[j][ACC_W-1:0];
  endtask

  task automatic fill_rom_test1();
    for (int a = 0; a < 2**ADDR_W; a++) rom[a] = {5'd31, 16'h0000};
    rom[10] = {5'd3, 16'h4000};
    for (int b = 0; b < NBIN; b++) pwr[b] = 32'd100;
    pwr[10] = 32'd1000;
  endtask

  task automatic applyStimulus(input int nsend, input int duty);
    int b = 0;
    int guard = 0;
    while (b < nsend && guard < GUARD) begin
      @(negedge clk);
      guard++;
      checkOutput("rom_addr", 64'(rom_addr), 64'(b));
      pwr_valid = ($urandom_range(0, 99) < duty);
      pwr_data  = pwr[b];
      if (pwr_valid && pwr_ready) begin
        b++;
        last_edge = cyc + 1;
      end
    end
    if (guard >= GUARD) checkOutput("send_timeout", 64'(b), 64'(nsend));
    @(negedge clk);
    pwr_valid = 1'b0;
  endtask

  task automatic collect_frame(input int ready_pct);
    int  k = 0;
    int  guard = 0;
    bit  first = 1'b1;
    while (k < NFILT && guard < GUARD) begin
      @(negedge clk);
      guard++;
      mel_ready = ($urandom_range(0, 99) < ready_pct);
      if (mel_valid) begin
        if (first) begin
          checkOutput("latency", 64'(cyc), 64'(last_edge + 3));
          first = 1'b0;
        end
        checkOutput("mel_idx", 64'(mel_idx), 64'(k));
        checkOutput("mel_data", 64'(mel_data), 64'(expv[k]));
        checkOutput("mel_last", 64'(mel_last), 64'(k == NFILT-1));
        if (mel_ready) begin
          got[k] = mel_data;
          k++;
        end
      end
    end
    if (guard >= GUARD) checkOutput("out_timeout", 64'(k), 64'(NFILT));
    @(negedge clk);
    mel_ready = 1'b0;
    checkOutput("ready_after_last", 64'(pwr_ready), 64'd1);
    checkOutput("valid_after_last", 64'(mel_valid), 64'd0);
  endtask

  task automatic run_frame(input int duty, input int ready_pct);
    build_model();
    fork
      applyStimulus(NBIN, duty);
      collect_frame(ready_pct);
    join
  endtask

  initial begin
    rst_n     = 1'b0;
    pwr_valid = 1'b0;
    pwr_data  = '0;
    mel_ready = 1'b0;
    fill_rom_test1();
    repeat (3) @(negedge clk);
    checkOutput("rst_pwr_ready", 64'(pwr_ready), 64'd0);
    checkOutput("rst_mel_valid", 64'(mel_valid), 64'd0);
    checkOutput("rst_mel_data", 64'(mel_data), 64'd0);
    checkOutput("rst_mel_idx", 64'(mel_idx), 64'd0);
    checkOutput("rst_mel_last", 64'(mel_last), 64'd0);
    checkOutput("rst_rom_addr", 64'(rom_addr), 64'd0);
    rst_n = 1'b1;

    $display("[TB] single-bin frame, continuous");
    run_frame(100, 100);
    checkOutput("t1_mel3", 64'(got[3]), 64'd16384000);
    checkOutput("t1_mel2", 64'(got[2]), 64'd49152000);

    $display("[TB] zero power frame");
    for (int a = 0; a < NBIN; a++) begin
      rom[a] = 21'($urandom);
      pwr[a] = '0;
    end
    run_frame(100, 100);

    $display("[TB] single-bin frame, random backpressure");
    fill_rom_test1();
    run_frame(100, 50);
    checkOutput("t3_mel3", 64'(got[3]), 64'd16384000);

    $display("[TB] random frame, continuous then gapped");
    for (int a = 0; a < NBIN; a++) begin
      rom[a] = {5'($urandom_range(0, 31)), 16'($urandom)};
      pwr[a] = $urandom;
    end
    run_frame(100, 100);
    run_frame(50, 60);

    $display("[TB] saturation frame");
    for (int a = 0; a < NBIN; a++) begin
      rom[a] = {5'd0, 16'hFFFF};
      pwr[a] = 32'hFFFF_FFFF;
    end
    run_frame(100, 100);
    checkOutput("t5_sat", 64'(got[0]), 64'({ACC_W{1'b1}}));

    $display("[TB] reset mid-frame then clean frame");
    fill_rom_test1();
    applyStimulus(100, 100);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_ready", 64'(pwr_ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_rom_addr", 64'(rom_addr), 64'd0);
    checkOutput("midrst_valid", 64'(mel_valid), 64'd0);
    run_frame(100, 70);
    checkOutput("t6_mel3", 64'(got[3]), 64'd16384000);
    checkOutput("t6_mel2", 64'(got[2]), 64'd49152000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
